ip_amba_axi_master_wdata_chnl: RTL

//  Write-data channel engine of the AXI master. Buffers application write data in an internal FIFO.

---
 rtl/ip_amba_axi_pkg.sv | 18 +
 rtl/ip_amba_axi_sync_fifo.sv | 61 ++++++
 rtl/ip_amba_axi_master_wdata_chnl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ip_amba_axi_pkg.sv
// Shared AXI master definitions: burst encodings, write-data FSM states, size decode.
package ip_amba_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BEAT = 1'b1
  } wstate_e;

  // Bytes per beat for an AxSIZE encoding.
  function automatic logic [7:0] size_to_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/ip_amba_axi_sync_fifo.sv
// First-word-fall-through synchronous FIFO; shared by the write- and read-data buffers.
module ip_amba_axi_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  // A push while full is dropped even when a pop happens in the same cycle.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: rtl/ip_amba_axi_master_wdata_chnl.sv
// AXI master write-data channel: buffers app data and issues W beats per accepted burst command.
// Define IP_AMBA_AXI_WSTRB_NARROW_EN for size/address-derived strobes; otherwise WSTRB is all ones.
module ip_amba_axi_master_wdata_chnl
  import ip_amba_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic [DATA_WIDTH-1:0]   from_app_wdata,
  input  logic                    from_app_wdata_push,
  output logic                    to_app_wdata_fulln,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic                    busy
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned MAX_SIZE = $clog2(STRB_W);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;

  wstate_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  wvalid, handshake, last_beat;
  logic [2:0]            cmd_size_eff;
  logic [ADDR_WIDTH-1:0] bytes_a, incr_addr, wrap_bytes, wrap_mask, next_addr;

  ip_amba_axi_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_wdata_fifo (
    .clk       (ACLK),
    .rst       (ARESET),
    .push      (from_app_wdata_push),
    .push_data (from_app_wdata),
    .pop       (handshake),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  assign cmd_size_eff = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;
  assign wvalid       = (state_q == ST_BEAT) && (fifo_count != '0);
  assign last_beat    = (beat_cnt_q == len_q);
  assign handshake    = wvalid & WREADY;

  // Next beat address; WRAP stays inside a (len+1)*bytes window.
  always_comb begin
    bytes_a    = ADDR_WIDTH'(size_to_bytes(size_q));
    incr_addr  = (addr_q & ~(bytes_a - ADDR_WIDTH'(1))) + bytes_a;
    wrap_bytes = ADDR_WIDTH'(({24'd0, len_q} + 32'd1) << size_q);
    wrap_mask  = wrap_bytes - ADDR_WIDTH'(1);
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          len_d      = cmd_len;
          size_d     = cmd_size_eff;
          burst_d    = cmd_burst;
          beat_cnt_d = 8'd0;
          state_d    = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (handshake) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          addr_d     = next_addr;
          if (last_beat) state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign cmd_ready          = (state_q == ST_IDLE);
  assign busy               = (state_q != ST_IDLE);
  assign to_app_wdata_fulln = ~fifo_full;
  assign WVALID             = wvalid;
  assign WLAST              = wvalid & last_beat;
  assign WDATA              = wvalid ? fifo_head : '0;

`ifdef IP_AMBA_AXI_WSTRB_NARROW_EN
  localparam int unsigned LANE_W = MAX_SIZE;

  logic [STRB_W-1:0] strb_narrow;

  // Lanes [base, base+bytes); the first beat also masks lanes below the start address.
  always_comb begin
    int unsigned lane, nbytes, lo, hi;
    lane   = 32'(addr_q[LANE_W-1:0]);
    nbytes = 32'(size_to_bytes(size_q));
    lo     = lane & ~(nbytes - 32'd1);
    hi     = lo + nbytes;
    if (beat_cnt_q == 8'd0) lo = lane;
    strb_narrow = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      strb_narrow[i] = (i >= lo) && (i < hi);
    end
  end

  assign WSTRB = wvalid ? strb_narrow : '0;
`else
  assign WSTRB = wvalid ? {STRB_W{1'b1}} : '0;
`endif

endmodule
